uart_frame_ctrl: RTL

Command-frame controller sitting between the UART byte receiver and the SDRAM access path. It parses framed byte streams (header, command, address, length, payload, optional checksum) from the receiver's `rx_data`/`rx_vld` outputs. It sequences them into per-byte write transfers, buffered through a small FIFO, or into single read requests. Errors are reported through a sticky status code.

---
 rtl/uart_frame_ctrl_pkg.sv | 29 ++
 rtl/uart_frame_ctrl_if.sv | 32 +++
 rtl/uart_frame_ctrl_sync_fifo.sv | 43 ++++
 rtl/uart_frame_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_ctrl_pkg.sv
// Shared types and constants for the UART command-frame controller.
// Checksum support is selected with the UART_FRAME_CSUM_EN macro.
package uart_frame_pkg;

  localparam int ADDR_W  = 24;
  localparam int ENTRY_W = ADDR_W + 8;

  localparam logic [7:0] CMD_WR = 8'h01;
  localparam logic [7:0] CMD_RD = 8'h02;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_CMD    = 3'd1;
  localparam state_t S_ADDR   = 3'd2;
  localparam state_t S_LEN    = 3'd3;
  localparam state_t S_DATA   = 3'd4;
  localparam state_t S_CSUM   = 3'd5;
  localparam state_t S_RD_REQ = 3'd6;
  localparam state_t S_DRAIN  = 3'd7;

  localparam logic [2:0] ERR_OK   = 3'd0;
  localparam logic [2:0] ERR_CMD  = 3'd1;
  localparam logic [2:0] ERR_LEN  = 3'd2;
  localparam logic [2:0] ERR_TMO  = 3'd3;
  localparam logic [2:0] ERR_CSUM = 3'd4;
  localparam logic [2:0] ERR_OVF  = 3'd5;

endpackage

// File: rtl/uart_frame_ctrl_if.sv
// Byte-receiver, write-FIFO and read-request signals of uart_frame_ctrl.
// master = the controller, slave = its environment.
interface uart_frame_ctrl_if;
  import uart_frame_pkg::*;

  logic [7:0]        rx_data;
  logic              rx_vld;
  logic              wr_vld;
  logic              wr_rdy;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              rd_req;
  logic              rd_ack;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_len;
  logic              busy;
  logic              frame_done;
  logic [2:0]        err_code;

  modport master (
    input  rx_data, rx_vld, wr_rdy, rd_ack,
    output wr_vld, wr_addr, wr_data, rd_req, rd_addr, rd_len,
           busy, frame_done, err_code
  );

  modport slave (
    output rx_data, rx_vld, wr_rdy, rd_ack,
    input  wr_vld, wr_addr, wr_data, rd_req, rd_addr, rd_len,
           busy, frame_done, err_code
  );

endinterface

// File: rtl/uart_frame_ctrl_sync_fifo.sv
// First-word fall-through FIFO; a push into a full FIFO is accepted when a
// pop happens in the same cycle. Head data reads as zero while empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/uart_frame_ctrl.sv
// Parses HEADER/cmd/addr/len/payload frames into buffered writes or a read request.
// Define UART_FRAME_CSUM_EN to expect a trailing XOR checksum byte.
//
// state  | meaning
// IDLE   | waiting for HEADER
// CMD    | expecting command byte
// ADDR   | collecting 3 address bytes, MSB first
// LEN    | expecting length byte
// DATA   | pushing payload bytes (or discarding after overflow)
// CSUM   | expecting checksum byte
// RD_REQ | holding rd_req until rd_ack
// DRAIN  | waiting for the write FIFO to empty
module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] HEADER     = 8'hA5,
  parameter int         TIMEOUT    = 26040,
  parameter int         FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  uart_frame_ctrl_if.master bus
);
  localparam int TMO_W = $clog2(TIMEOUT);
`ifdef UART_FRAME_CSUM_EN
  localparam logic [7:0] CSUM_EXTRA = 8'd1;
`else
  localparam logic [7:0] CSUM_EXTRA = 8'd0;
`endif

  state_t            state_q, state_d;
  logic              is_rd_q, is_rd_d;
  logic              discard_q, discard_d;
  logic              done_q, done_d;
  logic [1:0]        abyte_q, abyte_d;
  logic [2:0]        err_q, err_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
`ifdef UART_FRAME_CSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              rx_vld, push, pop, full, empty, active;
  logic [7:0]        rx_data, ovf_rem;
  logic [ENTRY_W-1:0] fifo_dout;

  assign rx_vld  = bus.rx_vld;
  assign rx_data = bus.rx_data;
  assign pop     = !empty && bus.wr_rdy;
  assign active  = (state_q inside {S_CMD, S_ADDR, S_LEN, S_DATA, S_CSUM});
  assign ovf_rem = cnt_q - 8'd1 + CSUM_EXTRA;

  always_comb begin
    state_d   = state_q;
    is_rd_d   = is_rd_q;
    discard_d = discard_q;
    done_d    = 1'b0;
    abyte_d   = abyte_q;
    err_d     = err_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    push      = 1'b0;
    tmo_d     = tmo_q;
    if (rx_vld || !active) tmo_d = TMO_W'(TIMEOUT - 1);
    else if (tmo_q != '0)  tmo_d = tmo_q - 1'b1;

    case (state_q)
      S_IDLE: if (rx_vld && rx_data == HEADER) begin
        state_d   = S_CMD;
        err_d     = ERR_OK;
        discard_d = 1'b0;
      end
      S_CMD: if (rx_vld) begin
        abyte_d = 2'd0;
        if (rx_data == CMD_WR || rx_data == CMD_RD) begin
          is_rd_d = (rx_data == CMD_RD);
          state_d = S_ADDR;
        end else begin
          err_d   = ERR_CMD;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ADDR: if (rx_vld) begin
        addr_d  = {addr_q[ADDR_W-9:0], rx_data};
        abyte_d = abyte_q + 2'd1;
        if (abyte_q == 2'd2) state_d = S_LEN;
      end
      S_LEN: if (rx_vld) begin
        len_d = rx_data;
        cnt_d = rx_data;
        if (rx_data == 8'd0) begin
          err_d   = ERR_LEN;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (!is_rd_q) begin
          state_d = S_DATA;
        end else begin
`ifdef UART_FRAME_CSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_RD_REQ;
`endif
        end
      end
      S_DATA: if (rx_vld) begin
        if (discard_q) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = S_DRAIN;
        end else if (full && !pop) begin
          // Remaining payload (and checksum) is consumed by count so it cannot start a new frame.
          err_d     = ERR_OVF;
          discard_d = 1'b1;
          cnt_d     = ovf_rem;
          if (ovf_rem == 8'd0) state_d = S_DRAIN;
        end else begin
          push   = 1'b1;
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
`ifdef UART_FRAME_CSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DRAIN;
`endif
          end
        end
      end
`ifdef UART_FRAME_CSUM_EN
      S_CSUM: if (rx_vld) begin
        if (rx_data != csum_q) err_d = ERR_CSUM;
        if (!is_rd_q)                state_d = S_DRAIN;
        else if (rx_data == csum_q)  state_d = S_RD_REQ;
        else begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
`endif
      S_RD_REQ: if (bus.rd_ack) begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_DRAIN: if (empty) begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: ;
    endcase

    if (active && !rx_vld && tmo_q == '0) begin
      err_d   = ERR_TMO;
      state_d = S_DRAIN;
    end

`ifdef UART_FRAME_CSUM_EN
    csum_d = csum_q;
    if (state_q == S_IDLE) csum_d = '0;
    else if ((rx_vld && state_q inside {S_CMD, S_ADDR, S_LEN}) || push)
      csum_d = csum_q ^ rx_data;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      is_rd_q   <= 1'b0;
      discard_q <= 1'b0;
      done_q    <= 1'b0;
      abyte_q   <= '0;
      err_q     <= ERR_OK;
      len_q     <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      tmo_q     <= TMO_W'(TIMEOUT - 1);
`ifdef UART_FRAME_CSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      is_rd_q   <= is_rd_d;
      discard_q <= discard_d;
      done_q    <= done_d;
      abyte_q   <= abyte_d;
      err_q     <= err_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      tmo_q     <= tmo_d;
`ifdef UART_FRAME_CSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   ({addr_q, rx_data}),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (full),
    .empty_o (empty)
  );

  assign bus.wr_vld     = !empty;
  assign bus.wr_addr    = fifo_dout[ENTRY_W-1:8];
  assign bus.wr_data    = fifo_dout[7:0];
  assign bus.rd_req     = (state_q == S_RD_REQ);
  assign bus.rd_addr    = addr_q;
  assign bus.rd_len     = len_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.frame_done = done_q;
  assign bus.err_code   = err_q;

endmodule
